// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt trap sequencer: arbitrates the three machine interrupt
// sources, waits for an instruction boundary, handshakes a pipeline flush and
// issues a one-cycle trap-entry strobe carrying mepc/mcause/handler PC. Further
// traps are held off until mret.
module irq_trap_sequencer #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        meip_in,
  input  logic        mtip_in,
  input  logic        msip_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic        msie_in,
  input  logic        mstatus_mie_in,
  input  logic        instr_boundary_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] mtvec_in,
  input  logic        flush_ack_in,
  input  logic        mret_in,
  output logic        flush_req_out,
  output logic        trap_taken_out,
  output logic        mepc_wr_out,
  output logic [31:0] mepc_out,
  output logic [31:0] mcause_out,
  output logic [31:0] trap_pc_out,
  output logic        busy_out
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_BND   = 3'd1,
    ST_FLUSH      = 3'd2,
    ST_ENTER      = 3'd3,
    ST_IN_HANDLER = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        irq_req_s;
  logic        latch_s;
  logic [4:0]  code_s;
  logic        flush_req_q;
  logic        trap_taken_q;
  logic        busy_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] trap_pc_q;

  // Fixed priority: external (11) over software (3) over timer (7).
  function automatic logic [4:0] irq_code(input logic ext_s, input logic sw_s);
    if (ext_s) begin
      return 5'd11;
    end else if (sw_s) begin
      return 5'd3;
    end else begin
      return 5'd7;
    end
  endfunction

  // Handler address: aligned base, plus 4*code when vectored mode is selected.
  function automatic logic [31:0] handler_pc(input logic [31:0] mtvec_s,
                                             input logic [4:0]  code_v);
    logic [31:0] base_s;
    base_s = {mtvec_s[31:2], 2'b00};
    if (VECTORED_EN && (mtvec_s[1:0] == 2'b01)) begin
      return base_s + {25'd0, code_v, 2'b00};
    end else begin
      return base_s;
    end
  endfunction

  // Qualified interrupt request and the winning cause code for this cycle.
  always_comb begin
    irq_req_s = mstatus_mie_in & ((meip_in & meie_in) |
                                  (msip_in & msie_in) |
                                  (mtip_in & mtie_in));
    code_s    = irq_code(meip_in & meie_in, msip_in & msie_in);
  end

  // Next-state logic; latch_s marks the edge that commits cause/mepc/handler PC.
  always_comb begin
    state_d = state_q;
    latch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (irq_req_s) begin
          state_d = ST_WAIT_BND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_BND: begin
        if (!irq_req_s) begin
          state_d = ST_IDLE;
        end else if (instr_boundary_in) begin
          state_d = ST_FLUSH;
          latch_s = 1'b1;
        end else begin
          state_d = ST_WAIT_BND;
        end
      end
      ST_FLUSH: begin
        if (flush_ack_in) begin
          state_d = ST_ENTER;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_ENTER: begin
        state_d = ST_IN_HANDLER;
      end
      ST_IN_HANDLER: begin
        if (mret_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IN_HANDLER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register and registered state decodes for the handshake outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      flush_req_q  <= 1'b0;
      trap_taken_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_req_q  <= (state_d == ST_FLUSH);
      trap_taken_q <= (state_d == ST_ENTER);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // Trap record, committed once at the boundary and held until the next commit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mepc_q    <= 32'h0000_0000;
      mcause_q  <= 32'h0000_0000;
      trap_pc_q <= 32'h0000_0000;
    end else if (latch_s) begin
      mepc_q    <= pc_in;
      mcause_q  <= {1'b1, 26'd0, code_s};
      trap_pc_q <= handler_pc(mtvec_in, code_s);
    end
  end

  assign flush_req_out  = flush_req_q;
  assign trap_taken_out = trap_taken_q;
  assign mepc_wr_out    = trap_taken_q;
  assign busy_out       = busy_q;
  assign mepc_out       = mepc_q;
  assign mcause_out     = mcause_q;
  assign trap_pc_out    = trap_pc_q;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Self-checking bench for irq_trap_sequencer: directed scenarios plus random
// traps; expected trap records are queued at the boundary and popped by a
// monitor whenever the DUT strobes trap entry.
module tb_irq_trap_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        meip_in, mtip_in, msip_in;
  logic        meie_in, mtie_in, msie_in;
  logic        mstatus_mie_in;
  logic        instr_boundary_in;
  logic [31:0] pc_in;
  logic [31:0] mtvec_in;
  logic        flush_ack_in;
  logic        mret_in;
  logic        flush_req_out;
  logic        trap_taken_out;
  logic        mepc_wr_out;
  logic [31:0] mepc_out;
  logic [31:0] mcause_out;
  logic [31:0] trap_pc_out;
  logic        busy_out;

  int checks   = 0;
  int failures = 0;
  logic [95:0] exp_q[$];
  logic        prev_tt = 1'b0;

  irq_trap_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
    .mstatus_mie_in(mstatus_mie_in),
    .instr_boundary_in(instr_boundary_in), .pc_in(pc_in), .mtvec_in(mtvec_in),
    .flush_ack_in(flush_ack_in), .mret_in(mret_in),
    .flush_req_out(flush_req_out), .trap_taken_out(trap_taken_out),
    .mepc_wr_out(mepc_wr_out), .mepc_out(mepc_out), .mcause_out(mcause_out),
    .trap_pc_out(trap_pc_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_lines();
    meip_in = 1'b0; mtip_in = 1'b0; msip_in = 1'b0;
    meie_in = 1'b0; mtie_in = 1'b0; msie_in = 1'b0;
    mstatus_mie_in = 1'b0;
  endtask

  task automatic rand_lines();
    {meip_in, mtip_in, msip_in, meie_in, mtie_in, msie_in, mstatus_mie_in} = 7'($urandom);
  endtask

  // Random pattern that is guaranteed to raise an interrupt request.
  task automatic rand_irq_lines();
    rand_lines();
    mstatus_mie_in = 1'b1;
    if (!((meip_in && meie_in) || (msip_in && msie_in) || (mtip_in && mtie_in))) begin
      mtip_in = 1'b1;
      mtie_in = 1'b1;
    end
  endtask

  // Reference: cause from the priority rule applied to the current lines.
  function automatic logic [31:0] model_cause();
    if (meip_in && meie_in) return 32'h8000_000B;
    else if (msip_in && msie_in) return 32'h8000_0003;
    else return 32'h8000_0007;
  endfunction

  // Reference: handler PC = aligned base (+ 4*code when mode is vectored).
  function automatic logic [31:0] model_tpc(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    int unsigned code;
    base = mtvec & 32'hFFFF_FFFC;
    code = cause & 32'h0000_001F;
    if ((mtvec & 32'h3) == 32'h1) return base + 32'(code * 4);
    else return base;
  endfunction

  // One full trap sequence; the caller has already set lines raising a request.
  task automatic do_trap(input logic [31:0] pc, input logic [31:0] mtvec,
                         input logic [31:0] ecause, input logic [31:0] etpc,
                         input int bnd_dly, input int ack_dly, input int hand_cyc,
                         input bit scramble);
    tick();
    @(negedge clk_in);
    chk("busy_wait_bnd", 32'(busy_out), 32'd1);
    chk("no_flush_wait_bnd", 32'(flush_req_out), 32'd0);
    for (int i = 0; i < bnd_dly; i++) tick();
    pc_in = pc; mtvec_in = mtvec; instr_boundary_in = 1'b1;
    exp_q.push_back({pc, ecause, etpc});
    tick();
    instr_boundary_in = 1'b0; pc_in = $urandom; mtvec_in = $urandom;
    for (int i = 0; i < ack_dly; i++) begin
      if (scramble) rand_lines();
      @(negedge clk_in);
      chk("flush_held", 32'(flush_req_out), 32'd1);
      tick();
    end
    flush_ack_in = 1'b1;
    @(negedge clk_in);
    chk("flush_at_ack", 32'(flush_req_out), 32'd1);
    tick();
    flush_ack_in = 1'b0;
    @(negedge clk_in);
    chk("trap_strobe", 32'(trap_taken_out), 32'd1);
    chk("flush_dropped", 32'(flush_req_out), 32'd0);
    tick();
    @(negedge clk_in);
    chk("trap_strobe_end", 32'(trap_taken_out), 32'd0);
    for (int i = 0; i < hand_cyc; i++) begin
      if (scramble) begin
        rand_lines();
        flush_ack_in = 1'($urandom);
      end
      @(negedge clk_in);
      chk("no_nest_flush", 32'(flush_req_out), 32'd0);
      chk("busy_handler", 32'(busy_out), 32'd1);
      tick();
    end
    flush_ack_in = 1'b0;
    if (scramble) rand_irq_lines();
    mret_in = 1'b1;
    tick();
    mret_in = 1'b0;
    clear_lines();
    @(negedge clk_in);
    chk("idle_after_mret", 32'(busy_out), 32'd0);
    tick();
  endtask

  // Monitor: pops the expected record on every trap-entry strobe.
  always @(negedge clk_in) begin
    logic [95:0] e;
    if (!rst_in) begin
      if (trap_taken_out || mepc_wr_out)
        chk("mepc_wr_eq_trap", 32'(mepc_wr_out), 32'(trap_taken_out));
      if (trap_taken_out) begin
        chk("trap_one_cycle", 32'(prev_tt), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_trap actual=trap expected=none");
        end else begin
          e = exp_q.pop_front();
          chk("mepc", mepc_out, e[95:64]);
          chk("mcause", mcause_out, e[63:32]);
          chk("trap_pc", trap_pc_out, e[31:0]);
        end
      end
    end
    prev_tt = trap_taken_out;
  end

  initial begin
    logic [31:0] pc, mtvec, ec;
    rst_in = 1'b1;
    clear_lines();
    instr_boundary_in = 1'b0; pc_in = 32'd0; mtvec_in = 32'd0;
    flush_ack_in = 1'b0; mret_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_flush", 32'(flush_req_out), 32'd0);
    chk("rst_trap", 32'(trap_taken_out), 32'd0);
    chk("rst_mepc", mepc_out, 32'd0);
    chk("rst_mcause", mcause_out, 32'd0);
    chk("rst_trap_pc", trap_pc_out, 32'd0);
    rst_in = 1'b0;
    tick();

    // Direct mode, timer interrupt, ack after 2 cycles.
    mtip_in = 1'b1; mtie_in = 1'b1; mstatus_mie_in = 1'b1;
    do_trap(32'h0000_0040, 32'h0000_0100, 32'h8000_0007, 32'h0000_0100, 0, 2, 2, 1'b0);

    // All three pending, vectored: external wins.
    {meip_in, mtip_in, msip_in, meie_in, mtie_in, msie_in, mstatus_mie_in} = 7'h7F;
    do_trap(32'h0000_1000, 32'h0000_0201, 32'h8000_000B, 32'h0000_022C, 1, 0, 1, 1'b0);

    // No nesting: MSI held 10 cycles in the handler, second trap follows mret.
    msip_in = 1'b1; msie_in = 1'b1; mstatus_mie_in = 1'b1;
    do_trap(32'h0000_2000, 32'h0000_0201, 32'h8000_0003, 32'h0000_020C, 0, 0, 10, 1'b0);
    msip_in = 1'b1; msie_in = 1'b1; mstatus_mie_in = 1'b1;
    do_trap(32'h0000_2004, 32'h0000_0201, 32'h8000_0003, 32'h0000_020C, 0, 1, 0, 1'b0);

    // Masking by mstatus.MIE.
    meip_in = 1'b1; meie_in = 1'b1; mstatus_mie_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk_in);
      chk("masked_idle", 32'(busy_out), 32'd0);
    end

    // Enable cleared in WAIT_BND cancels the sequence.
    mstatus_mie_in = 1'b1;
    tick();
    @(negedge clk_in);
    chk("cancel_wait_busy", 32'(busy_out), 32'd1);
    meie_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk_in);
      chk("cancel_idle", 32'(busy_out), 32'd0);
      chk("cancel_no_flush", 32'(flush_req_out), 32'd0);
    end
    clear_lines();
    tick();

    // Flush stall of 20 cycles with pending lines churning.
    meip_in = 1'b1; meie_in = 1'b1; mstatus_mie_in = 1'b1;
    do_trap(32'h0000_3000, 32'h0000_0301, 32'h8000_000B, 32'h0000_032C, 0, 20, 3, 1'b1);

    // Reset asserted mid-FLUSH aborts immediately.
    mtip_in = 1'b1; mtie_in = 1'b1; mstatus_mie_in = 1'b1;
    tick();
    pc_in = 32'h0000_0040; mtvec_in = 32'h0000_0100; instr_boundary_in = 1'b1;
    tick();
    instr_boundary_in = 1'b0;
    @(negedge clk_in);
    chk("pre_rst_flush", 32'(flush_req_out), 32'd1);
    tick();
    rst_in = 1'b1;
    #2;
    chk("rst_mid_flush", 32'(flush_req_out), 32'd0);
    chk("rst_mid_busy", 32'(busy_out), 32'd0);
    chk("rst_mid_mepc", mepc_out, 32'd0);
    chk("rst_mid_mcause", mcause_out, 32'd0);
    chk("rst_mid_trap_pc", trap_pc_out, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    clear_lines();
    tick();

    // Random traps checked against the reference model.
    for (int n = 0; n < 30; n++) begin
      rand_irq_lines();
      mtvec = $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      ec = model_cause();
      do_trap(pc, mtvec, ec, model_tpc(mtvec, ec), int'($urandom % 4), int'($urandom % 6),
              int'($urandom % 5), 1'b1);
    end

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_trap_sequencer.md
# irq_trap_sequencer

Machine-mode interrupt trap sequencer for the RV32 core. It combines the pending interrupt lines with the `mie` enable bits (`meie`/`mtie`/`msie`) and `mstatus.MIE`, and picks the highest-priority interrupt. It then waits for an instruction boundary, handshakes a pipeline flush with the core, and issues a one-cycle trap-entry event. That event carries `mepc`, `mcause` and the `mtvec`-derived handler PC, and the block holds off further traps until `mret`.

## Interface
- `VECTORED_EN`, default 1 — when 0, `mtvec` mode bits are ignored and all traps are direct.
- `clk_in`  input  1  — core clock; all state updates on the rising edge.
- `rst_in`  input  1  — reset, asynchronous and active-high.
- `meip_in`, `mtip_in`, `msip_in`  input  1 each  — raw level pending lines: external, timer, software.
- `meie_in`, `mtie_in`, `msie_in`  input  1 each  — enables from the `mie` register.
- `mstatus_mie_in`  input  1  — global machine interrupt enable.
- `instr_boundary_in`  input  1  — core is at a precise instruction boundary this cycle; `pc_in` is the next unexecuted instruction.
- `pc_in`  input  32  — PC to save as `mepc`.
- `mtvec_in`  input  32  — `mtvec` CSR value; [1:0] is the mode.
- `flush_ack_in`  input  1  — core has completed the pipeline flush.
- `mret_in`  input  1  — `mret` retired this cycle.
- `flush_req_out`  output  1  — request pipeline flush; level, held until acknowledged.
- `trap_taken_out`  output  1  — one-cycle trap-entry strobe.
- `mepc_wr_out`  output  1  — write strobe for `mepc`/`mcause`; equals `trap_taken_out`.
- `mepc_out`  output  32  — latched interrupted PC.
- `mcause_out`  output  32  — latched cause.
- `trap_pc_out`  output  32  — handler fetch address.
- `busy_out`  output  1  — high in every state except IDLE.

## Operation
- `irq_req = mstatus_mie_in & ((meip_in & meie_in) | (msip_in & msie_in) | (mtip_in & mtie_in))`.
- Priority is fixed, highest first:
  - MEI → code 11.
  - MSI → code 3.
  - MTI → code 7.
- `mcause` is `{1'b1, 26'b0, code[4:0]}`, giving 0x8000000B, 0x80000003 or 0x80000007.
- Handler PC:
  - Base is `{mtvec_in[31:2], 2'b00}`.
  - If `VECTORED_EN` and `mtvec_in[1:0]==2'b01`, the handler PC is base + 4×code, computed mod 2^32 with the carry discarded.
  - Modes 00, 10 and 11 use base only.
- FSM states: IDLE, WAIT_BND, FLUSH, ENTER, IN_HANDLER.
- IDLE:
  - `irq_req` → WAIT_BND.
- WAIT_BND:
  - If `irq_req` is 0 → IDLE, with no trap and no side effects. This covers a source deasserting or an enable being cleared.
  - Else if `instr_boundary_in` → FLUSH. On the same edge, latch the cause (priority evaluated in that cycle), `mepc_out <= pc_in`, and `trap_pc_out`, computed from `mtvec_in` in that cycle.
- FLUSH:
  - `flush_req_out=1`.
  - `flush_ack_in` → ENTER.
  - Pending-line changes are ignored; the cause is already committed.
- ENTER:
  - `trap_taken_out=1` and `mepc_wr_out=1` for exactly one cycle.
  - Unconditional → IN_HANDLER.
- IN_HANDLER:
  - No nesting; `irq_req` is ignored.
  - `mret_in` → IDLE.
- `mret_in` outside IN_HANDLER is ignored.
- `flush_ack_in` outside FLUSH is ignored.
- `mepc_out`, `mcause_out` and `trap_pc_out` hold their latched values until the next WAIT_BND→FLUSH transition.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert handled externally):
  - State = IDLE.
  - All outputs 0, including `mepc_out`, `mcause_out` and `trap_pc_out` (0x00000000).
- Reset asserted in any state aborts the sequence immediately. `flush_req_out` and `trap_taken_out` drop in the same cycle.
- `flush_req_out` and `trap_taken_out` are registered state decodes, with no combinational path from any input.
- Best case:
  - Cycle 0: `irq_req` rises.
  - Edge 1: enter WAIT_BND.
  - Cycle 1: `instr_boundary_in` high.
  - Edge 2: enter FLUSH, with `flush_req_out=1` in cycle 2.
  - Cycle 2: `flush_ack_in` high.
  - Edge 3: enter ENTER, with `trap_taken_out=1` in cycle 3.
  - Edge 4: enter IN_HANDLER.
- Minimum latency from `irq_req` to `trap_taken_out` is 3 cycles.
- After `mret_in`, IDLE is reached on the next edge. An `irq_req` still high re-enters WAIT_BND one edge later, so there are at least 2 cycles between `mret_in` and the next `flush_req_out`.
- `mret_in` and `irq_req` high in the same IN_HANDLER cycle: `mret_in` wins, go to IDLE.

## Test plan
- Reset: hold `rst_in`=1 mid-FLUSH → `flush_req_out`=0, `busy_out`=0, all 32-bit outputs 0x00000000.
- Direct mode:
  - Stimulus: `mtvec_in`=0x00000100, `mtip_in`=`mtie_in`=`mstatus_mie_in`=1, boundary with `pc_in`=0x00000040, ack after 2 cycles.
  - Response: `trap_taken_out` pulse of exactly 1 cycle, `mcause_out`=0x80000007, `mepc_out`=0x00000040, `trap_pc_out`=0x00000100.
- Priority plus vectored mode:
  - Stimulus: all three sources pending and enabled, `mtvec_in`=0x00000201.
  - Response: `mcause_out`=0x8000000B, `trap_pc_out`=0x0000022C. With only MSI pending, `trap_pc_out`=0x0000020C.
- Masking:
  - `mstatus_mie_in`=0 with `meip_in`=`meie_in`=1 → FSM stays IDLE, `busy_out`=0.
  - Clearing `meie_in` during WAIT_BND → back to IDLE, no `flush_req_out`.
- No nesting:
  - Stimulus: in IN_HANDLER, assert MSI for 10 cycles, then `mret_in`.
  - Response: no `flush_req_out` before `mret_in`; a second trap with `mcause_out`=0x80000003 follows.
- Flush stall: hold `flush_ack_in`=0 for 20 cycles → `flush_req_out` stays high, pending changes are ignored, and the cause is unchanged at entry.
